mips_mult_scheduler: RTL
========================

// Module: mips_mult_scheduler
// PURPOSE
//  Issue scheduler for the 4-stage pipelined multiplier (P0..P3, writeback W).
//  Sits beside the decode stage. It tracks in-flight multiplies with a valid/dest shift pipe and a
//  per-register busy scoreboard, and arbitrates the single RF write port between ALU and multiplier results.
//  It raises a decode stall on RAW, WAW and write-port hazards, and emits the multiplier writeback strobe and address.
// PARAMETERS
//  REG_ADDR_W  5  register address width; NREG = 2**REG_ADDR_W
//  MULT_LAT    4  multiplier pipe stages; mult result written MULT_LAT+1 cycles after issue
//  ALU_LAT     3  cycles from ALU-op issue to its RF write; legal range 1..MULT_LAT
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           reset, asynchronous, active-low (0 = reset)
//  mult_req_D     in   1           decode holds a multiply
//  mult_dest_D    in   REG_ADDR_W  multiply destination register
//  alu_wr_D       in   1           decode holds a non-multiply op that writes the RF
//  alu_dest_D     in   REG_ADDR_W  destination of that op
//  src_a_D        in   REG_ADDR_W  decode source A address
//  src_b_D        in   REG_ADDR_W  decode source B address
//  src_a_used_D   in   1           source A is actually read
//  src_b_used_D   in   1           source B is actually read
//  kill_D         in   1           decode instruction squashed; never issues, never stalls
//  stall          out  1           hold fetch/decode this cycle
//  mult_issue     out  1           multiply accepted this cycle (mult_req_D & ~stall & ~kill_D)
//  mult_wb_valid  out  1           multiplier owns the RF write port this cycle
//  mult_wb_addr   out  REG_ADDR_W  register written by the multiplier
//  busy_mask      out  NREG        scoreboard, bit r = pending multiply to r
//  inflight_cnt   out  $clog2(MULT_LAT+2)  number of multiplies in P0..W
// BEHAVIOUR
//  Reset (rst=0, async): vld[*]=0, dst[*]=0, busy_mask=0, inflight_cnt=0.
//   Hence stall=0, mult_issue=0, mult_wb_valid=0, mult_wb_addr=0.
//  Pipe: vld[0..MULT_LAT], dst[0..MULT_LAT], all flops.
//   vld[0] <= mult_issue; dst[0] <= mult_dest_D; stage k+1 <= stage k every cycle.
//   The pipe never freezes, and stall does not hold it.
//  mult_wb_valid = vld[MULT_LAT]; mult_wb_addr = vld[MULT_LAT] ? dst[MULT_LAT] : 0.
//  Scoreboard, next state:
//   - set bit mult_dest_D on mult_issue (dest != 0);
//   - clear bit dst[MULT_LAT] when vld[MULT_LAT];
//   - if set and clear hit the same bit in one cycle, set wins (unreachable by the WAW rule).
//  Register 0 is never busy; writes to r0 still consume the write port.
//  Hazards (combinational; all zero when kill_D=1):
//   raw  = (src_a_used_D & busy[src_a_D]) | (src_b_used_D & busy[src_b_D])
//          applies to any instruction, mult or ALU; no bypass.
//          A register in W still stalls; it is readable the cycle after W.
//   waw  = (mult_req_D & busy[mult_dest_D]) | (alu_wr_D & busy[alu_dest_D])
//   port = alu_wr_D & ~mult_req_D & vld[MULT_LAT-ALU_LAT]
//          with defaults this is the multiply in P1, which would collide with the ALU op at W.
//   stall = (mult_req_D | alu_wr_D | src_*_used_D) & (raw | waw | port)
//  The stalled instruction is re-evaluated every cycle; stall drops once the blocking entry leaves the pipe.
//  inflight_cnt = popcount(vld[0..MULT_LAT]); +1 on issue, -1 on writeback, unchanged if both.
//  Max in flight is MULT_LAT+1 (back-to-back issue to distinct dests); no overflow possible.
//  mult_req_D and alu_wr_D are mutually exclusive by decode; if both are 1, mult_req_D wins
//   and alu_wr_D is ignored for port.
//  Reset mid-operation drops all in-flight entries; no writeback strobes follow.
// TESTING
//  1 Reset: hold rst=0 with mult_req_D=1 -> stall=0, mult_issue=0, busy_mask=0, inflight_cnt=0.
//  2 Latency: mult dest r5 issued at cycle 0.
//    -> busy_mask[5]=1 in cycles 1..5; mult_wb_valid=1 with mult_wb_addr=5 in cycle 5.
//    -> busy_mask[5]=0 in cycle 6.
//  3 RAW: mult dest r5 at cycle 0; add reading r5 (src_a_used_D=1) in cycle 1.
//    -> stall=1 in cycles 1..5, stall=0 in cycle 6.
//  4 Port: mult dest r7 at cycle 0; ALU op writing r9 (no sources busy) in cycle 1 -> stall=0.
//    Same op in cycle 2 (mult in P1) -> stall=1 for one cycle, issues in cycle 3.
//  5 Throughput/WAW: five mults to r1..r5 on consecutive cycles -> no stalls; inflight_cnt reaches 5.
//    A sixth mult to r3 -> stall until r3's writeback cycle passes.
//  6 Kill/reset: kill_D=1 with mult_req_D=1 on busy r5 -> stall=0, mult_issue=0.
//    rst=0 while 3 mults in flight -> mult_wb_valid never asserts afterwards.

Source files
------------

// File: rtl/mips_mult_scheduler.sv
// mips_mult_scheduler: issue scheduler and RF write-port arbiter for the pipelined multiplier
module mips_mult_scheduler #(
    parameter int REG_ADDR_W = 5,
    parameter int MULT_LAT   = 4,
    parameter int ALU_LAT    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mult_req_D,
    input  logic [REG_ADDR_W-1:0]             mult_dest_D,
    input  logic                              alu_wr_D,
    input  logic [REG_ADDR_W-1:0]             alu_dest_D,
    input  logic [REG_ADDR_W-1:0]             src_a_D,
    input  logic [REG_ADDR_W-1:0]             src_b_D,
    input  logic                              src_a_used_D,
    input  logic                              src_b_used_D,
    input  logic                              kill_D,
    output logic                              stall,
    output logic                              mult_issue,
    output logic                              mult_wb_valid,
    output logic [REG_ADDR_W-1:0]             mult_wb_addr,
    output logic [(1<<REG_ADDR_W)-1:0]        busy_mask,
    output logic [$clog2(MULT_LAT+2)-1:0]     inflight_cnt
);
    localparam int NREG  = 1 << REG_ADDR_W;
    localparam int CNT_W = $clog2(MULT_LAT+2);

    logic [MULT_LAT:0]   vld;
    logic [REG_ADDR_W-1:0] dst [0:MULT_LAT];
    logic [NREG-1:0]     set_vec, clr_vec, busy_nxt;
    logic                raw, waw, port;

    assign raw  = (src_a_used_D & busy_mask[src_a_D]) | (src_b_used_D & busy_mask[src_b_D]);
    assign waw  = (mult_req_D & busy_mask[mult_dest_D]) | (alu_wr_D & busy_mask[alu_dest_D]);
    // ALU op issued now would reach W together with the multiply sitting at this stage
    assign port = alu_wr_D & ~mult_req_D & vld[MULT_LAT-ALU_LAT];

    assign stall      = ~kill_D & (mult_req_D | alu_wr_D | src_a_used_D | src_b_used_D) & (raw | waw | port);
    assign mult_issue = rst & mult_req_D & ~stall & ~kill_D;

    assign mult_wb_valid = vld[MULT_LAT];
    assign mult_wb_addr  = vld[MULT_LAT] ? dst[MULT_LAT] : '0;

    // r0 is never marked busy; set wins over clear on the same bit
    assign set_vec  = (mult_issue && mult_dest_D != '0) ? (NREG'(1) << mult_dest_D) : '0;
    assign clr_vec  = vld[MULT_LAT] ? (NREG'(1) << dst[MULT_LAT]) : '0;
    assign busy_nxt = (busy_mask & ~clr_vec) | set_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld          <= '0;
            for (int k = 0; k <= MULT_LAT; k++) dst[k] <= '0;
            busy_mask    <= '0;
            inflight_cnt <= '0;
        end else begin
            vld          <= {vld[MULT_LAT-1:0], mult_issue};
            dst[0]       <= mult_dest_D;
            for (int k = 1; k <= MULT_LAT; k++) dst[k] <= dst[k-1];
            busy_mask    <= busy_nxt;
            inflight_cnt <= inflight_cnt + CNT_W'(mult_issue) - CNT_W'(vld[MULT_LAT]);
        end
    end
endmodule
